demux8_capture_arb: RTL and testbench
=====================================

// Module: demux8_capture_arb
// PURPOSE
//  Sits directly downstream of demux_1_8 and consumes its eight outputs y0..y7.
//  Counts events per channel into saturating counters.
//  Drains pending channels one at a time onto a single valid/ready output port,
//  using round-robin priority.
//  Converts the demux's one-hot, unbuffered pulses into a loss-free, back-pressurable
//  event report stream.
// PARAMETERS
//  CNT_W      4  width of each per-channel event counter (saturates at 2**CNT_W-1)
//  EDGE_MODE  1  1: event = rising edge of yk; 0: event = every clock cycle yk is high
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  rst_n      in   1      asynchronous active-low reset
//  y0..y7     in   1 ea   demux_1_8 outputs, sampled on clk (synchronous to clk)
//  out_valid  out  1      report available
//  out_ready  in   1      consumer accepts report when out_valid & out_ready
//  out_ch     out  3      channel index of report (matches demux select s)
//  out_cnt    out  CNT_W  events accumulated on out_ch since its last report
//  pending    out  8      bit k set while channel k has a non-zero unreported count
//  overflow   out  8      sticky bit k: channel k counter saturated and an event was dropped
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - all counters cleared; pending=0, overflow=0
//   - out_valid=0, out_ch=0, out_cnt=0
//   - rr pointer=0; edge-detect history regs=0; FSM=IDLE
//  Event detect:
//   - y registered once (y_q)
//   - EDGE_MODE=1: ev[k] = y_q[k] & ~y_q_d[k]
//   - EDGE_MODE=0: ev[k] = y_q[k]
//   - yk high in cycle N gives ev[k] in cycle N+1; counter increments at end of N+1
//  Counters:
//   - cnt[k] += ev[k], saturating at all-ones
//   - ev[k] while cnt[k] is all-ones: no increment, overflow[k] set (sticky until reset)
//   - pending[k] = (cnt[k] != 0)
//  FSM states:
//   IDLE:
//    - if pending != 0: pick first set bit at or after rr pointer (wrap 7 -> 0)
//    - load out_ch=k, out_cnt=cnt[k] (including an ev[k] in that same cycle)
//    - clear cnt[k]; out_valid=1; go to PRESENT
//   PRESENT:
//    - out_valid, out_ch, out_cnt held stable until out_valid & out_ready
//    - on handshake: out_valid=0; rr pointer = out_ch+1 (mod 8); go to IDLE
//    - no back-to-back reports: one IDLE cycle between reports (max 1 report / 2 clk)
//    - events on any channel, including the presented one, keep counting into cnt[]
//      and are reported later; no event is lost unless its counter saturates
//  Latency: yk rises in cycle N with FSM idle -> out_valid=1 in cycle N+3 (EDGE_MODE=1)
//  Simultaneous events: multiple ev bits in one cycle each increment their own counter
//   (the demux guarantees one-hot, but the block must not depend on it)
//  Reset mid-report: out_valid drops immediately; the in-flight report and all counts
//   are discarded
//  out_ready is ignored while out_valid=0
// TESTING
//  T1 reset: rst_n=0 with y=8'hFF -> out_valid=0, pending=0, overflow=0;
//     release -> first report appears only after y activity per EDGE_MODE
//  T2 single pulse: y3=1 for one cycle, out_ready=1 -> exactly one report
//     {out_ch=3, out_cnt=1}, then pending=0
//  T3 round-robin: drive s=0..7 sequentially with i=1 through demux_1_8 while
//     out_ready=0, then release -> reports out_ch 0,1,...,7 each with out_cnt=1
//  T4 back-pressure: y5 pulses 3 times while out_ready=0 and ch5 is presented with
//     out_cnt=1 -> outputs held stable; after accept, next ch5 report has out_cnt=3
//  T5 saturation (CNT_W=4): 17 edges on y6 with out_ready=0 and ch6 not yet loaded
//     -> report out_cnt=15, overflow[6]=1 and stays 1
//  T6 mode/reset: EDGE_MODE=0, y1 held high 4 cycles -> out_cnt total 4;
//     assert rst_n while out_valid=1 -> out_valid=0 asynchronously, counts cleared

Source files
------------

// File: rtl/demux8_capture_arb.sv
// Captures the one-hot pulses of demux_1_8 into per-channel saturating counters
// and drains them round-robin as a loss-free valid/ready report stream.
module demux8_capture_arb #(
    parameter int unsigned CNT_W     = 4,
    parameter bit          EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    input  logic             y4,
    input  logic             y5,
    input  logic             y6,
    input  logic             y7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_ch,
    output logic [CNT_W-1:0] out_cnt,
    output logic [7:0]       pending,
    output logic [7:0]       overflow
);

    localparam int unsigned      N_CH    = 8;
    localparam int unsigned      CH_W    = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CH_W-1:0]  rr_q;
    logic [CH_W-1:0]  rr_d;
    logic             out_valid_d;
    logic [CH_W-1:0]  out_ch_d;
    logic [CNT_W-1:0] out_cnt_d;

    logic [N_CH-1:0]  y_vec;
    logic [N_CH-1:0]  y_q;
    logic [N_CH-1:0]  y_q_d;
    logic [N_CH-1:0]  ev;

    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_inc [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  ovf_set;
    logic [N_CH-1:0]  clr_mask;
    logic [N_CH-1:0]  pending_d;

    logic             pick_found;
    logic [CH_W-1:0]  pick_ch;

    assign y_vec = {y7, y6, y5, y4, y3, y2, y1, y0};

    // Single capture stage plus one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            y_q_d <= '0;
        end else begin
            y_q   <= y_vec;
            y_q_d <= y_q;
        end
    end

    assign ev = EDGE_MODE ? (y_q & ~y_q_d) : y_q;

    // Saturating increment; an event on a full counter is dropped and flagged
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ovf_set[k] = ev[k] && (cnt_q[k] == CNT_MAX);
            cnt_inc[k] = (ev[k] && !ovf_set[k]) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
        end
    end

    // The channel being loaded for report restarts from zero this cycle
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k]     = clr_mask[k] ? '0 : cnt_inc[k];
            pending_d[k] = (cnt_d[k] != '0);
        end
    end

    // Round-robin search: first pending channel at or after the pointer
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = rr_q;
        for (int i = 0; i < N_CH; i++) begin
            if (!pick_found && pending[rr_q + CH_W'(i)]) begin
                pick_found = 1'b1;
                pick_ch    = rr_q + CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        out_valid_d = out_valid;
        out_ch_d    = out_ch;
        out_cnt_d   = out_cnt;
        clr_mask    = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    out_valid_d       = 1'b1;
                    out_ch_d          = pick_ch;
                    out_cnt_d         = cnt_inc[pick_ch];
                    clr_mask[pick_ch] = 1'b1;
                    state_d           = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rr_d        = out_ch + CH_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            out_valid <= out_valid_d;
            out_ch    <= out_ch_d;
            out_cnt   <= out_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= '0;
            end
            pending  <= '0;
            overflow <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            pending  <= pending_d;
            overflow <= overflow | ovf_set;
        end
    end

endmodule

// File: tb/tb_demux8_capture_arb.sv
// Scoreboard bench for demux8_capture_arb: edge-mode instance checked through a
// report queue, level-mode instance used for level counting and mid-report reset.
module tb_demux8_capture_arb;

    typedef struct packed {
        logic [2:0] ch;
        logic [3:0] cnt;
    } rep_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] y_a     = 8'h00;
    logic [7:0] y_b     = 8'h00;
    logic       ready_a = 1'b0;
    logic       ready_b = 1'b0;
    logic       valid_a;
    logic       valid_b;
    logic [2:0] ch_a;
    logic [2:0] ch_b;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic [7:0] pend_a;
    logic [7:0] pend_b;
    logic [7:0] ovf_a;
    logic [7:0] ovf_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    rep_t exp_q[$];
    bit   hs_prev = 1'b0;

    always #5 clk = ~clk;

    demux8_capture_arb #(.CNT_W(4), .EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .y0(y_a[0]), .y1(y_a[1]), .y2(y_a[2]), .y3(y_a[3]),
        .y4(y_a[4]), .y5(y_a[5]), .y6(y_a[6]), .y7(y_a[7]),
        .out_valid(valid_a), .out_ready(ready_a), .out_ch(ch_a), .out_cnt(cnt_a),
        .pending(pend_a), .overflow(ovf_a)
    );

    demux8_capture_arb #(.CNT_W(4), .EDGE_MODE(1'b0)) dut_lvl (
        .clk(clk), .rst_n(rst_n),
        .y0(y_b[0]), .y1(y_b[1]), .y2(y_b[2]), .y3(y_b[3]),
        .y4(y_b[4]), .y5(y_b[5]), .y6(y_b[6]), .y7(y_b[7]),
        .out_valid(valid_b), .out_ready(ready_b), .out_ch(ch_b), .out_cnt(cnt_b),
        .pending(pend_b), .overflow(ovf_b)
    );

    // Scoreboard: every accepted report on the edge-mode instance is popped and compared
    always @(negedge clk) begin
        if (rst_n) begin
            if (hs_prev) begin
                n_tests++;
                if (valid_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_gap: out_valid=%b right after accept, required 0", valid_a);
                end
            end
            hs_prev = (valid_a === 1'b1) && (ready_a === 1'b1);
            if (hs_prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL report_unexpected: got ch=%0d cnt=%0d, required no report", ch_a, cnt_a);
                end else begin
                    rep_t e;
                    e = exp_q.pop_front();
                    if ({ch_a, cnt_a} !== {e.ch, e.cnt}) begin
                        n_fail++;
                        $display("FAIL report_content: got ch=%0d cnt=%0d, required ch=%0d cnt=%0d",
                                 ch_a, cnt_a, e.ch, e.cnt);
                    end
                end
            end
        end else begin
            hs_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            y_a[ch] = 1'b1;
            tick();
            y_a[ch] = 1'b0;
            tick();
        end
    endtask

    task automatic wait_valid_a(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (valid_a !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid_timeout: out_valid=%b, required 1", tag, valid_a);
        end
    endtask

    task automatic drain_a(input string tag);
        int i;
        i = 0;
        ready_a = 1'b1;
        while (exp_q.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || valid_a !== 1'b0 || pend_a !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_drain: left=%0d out_valid=%b pending=%h, required 0/0/00",
                     tag, exp_q.size(), valid_a, pend_a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        y_a = 8'hFF;
        y_b = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (valid_a !== 1'b0 || pend_a !== 8'h00 || ovf_a !== 8'h00 || ch_a !== 3'd0 || cnt_a !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_edge: valid=%b pend=%h ovf=%h ch=%0d cnt=%0d, required all 0",
                     valid_a, pend_a, ovf_a, ch_a, cnt_a);
        end
        n_tests++;
        if (valid_b !== 1'b0 || pend_b !== 8'h00 || ovf_b !== 8'h00 || ch_b !== 3'd0 || cnt_b !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_level: valid=%b pend=%h ovf=%h ch=%0d cnt=%0d, required all 0",
                     valid_b, pend_b, ovf_b, ch_b, cnt_b);
        end
        y_a = 8'h00;
        y_b = 8'h00;
        tick();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_tests++;
            if (valid_a !== 1'b0 || pend_a !== 8'h00 || valid_b !== 1'b0 || pend_b !== 8'h00) begin
                n_fail++;
                $display("FAIL quiet_after_reset: valid=%b/%b pend=%h/%h, required 0/0 00/00",
                         valid_a, valid_b, pend_a, pend_b);
            end
        end
    endtask

    task automatic test_single_pulse();
        ready_a = 1'b1;
        exp_q.push_back(rep_t'{3'd3, 4'd1});
        tick();
        y_a[3] = 1'b1;
        tick();
        y_a[3] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_n1: out_valid=%b, required 0", valid_a);
        end
        @(negedge clk);
        n_tests++;
        if (valid_a !== 1'b0 || pend_a !== 8'h08) begin
            n_fail++;
            $display("FAIL latency_n2: out_valid=%b pending=%h, required 0 08", valid_a, pend_a);
        end
        @(negedge clk);
        n_tests++;
        if (valid_a !== 1'b1 || pend_a !== 8'h00) begin
            n_fail++;
            $display("FAIL latency_n3: out_valid=%b pending=%h, required 1 00", valid_a, pend_a);
        end
        drain_a("single");
    endtask

    task automatic test_round_robin();
        ready_a = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(rep_t'{3'(k), 4'd1});
        for (int k = 0; k < 8; k++) begin
            y_a = 8'b1 << k;
            tick();
        end
        y_a = 8'h00;
        wait_valid_a("rr");
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if (valid_a !== 1'b1 || ch_a !== 3'd0 || cnt_a !== 4'd1 || pend_a !== 8'hFE) begin
                n_fail++;
                $display("FAIL rr_hold: valid=%b ch=%0d cnt=%0d pend=%h, required 1 0 1 fe",
                         valid_a, ch_a, cnt_a, pend_a);
            end
        end
        drain_a("rr");
    endtask

    task automatic test_back_pressure();
        ready_a = 1'b0;
        exp_q.push_back(rep_t'{3'd5, 4'd1});
        exp_q.push_back(rep_t'{3'd5, 4'd3});
        y_a[5] = 1'b1;
        tick();
        y_a[5] = 1'b0;
        wait_valid_a("bp");
        pulse_a(5, 3);
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (valid_a !== 1'b1 || ch_a !== 3'd5 || cnt_a !== 4'd1 || pend_a !== 8'h20) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b ch=%0d cnt=%0d pend=%h, required 1 5 1 20",
                         valid_a, ch_a, cnt_a, pend_a);
            end
        end
        drain_a("bp");
    endtask

    task automatic test_saturation();
        ready_a = 1'b0;
        exp_q.push_back(rep_t'{3'd2, 4'd1});
        exp_q.push_back(rep_t'{3'd6, 4'd15});
        y_a[2] = 1'b1;
        tick();
        y_a[2] = 1'b0;
        wait_valid_a("sat");
        pulse_a(6, 17);
        repeat (2) @(negedge clk);
        n_tests++;
        if (ovf_a !== 8'h40 || pend_a !== 8'h40 || valid_a !== 1'b1 || ch_a !== 3'd2) begin
            n_fail++;
            $display("FAIL sat_flag: ovf=%h pend=%h valid=%b ch=%0d, required 40 40 1 2",
                     ovf_a, pend_a, valid_a, ch_a);
        end
        drain_a("sat");
        repeat (3) @(negedge clk);
        n_tests++;
        if (ovf_a !== 8'h40) begin
            n_fail++;
            $display("FAIL sat_sticky: ovf=%h, required 40", ovf_a);
        end
    endtask

    task automatic test_level_mode();
        int sum;
        int nrep;
        sum  = 0;
        nrep = 0;
        ready_b = 1'b0;
        y_b[1] = 1'b1;
        repeat (4) tick();
        y_b[1] = 1'b0;
        ready_b = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (valid_b === 1'b1) begin
                nrep++;
                sum += int'(cnt_b);
                n_tests++;
                if (ch_b !== 3'd1) begin
                    n_fail++;
                    $display("FAIL level_ch: got ch=%0d, required 1", ch_b);
                end
            end
        end
        n_tests++;
        if (sum != 4 || nrep == 0 || pend_b !== 8'h00 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL level_total: sum=%0d reports=%0d pend=%h valid=%b, required 4 >0 00 0",
                     sum, nrep, pend_b, valid_b);
        end
    endtask

    task automatic test_reset_mid_report();
        int i;
        i = 0;
        ready_b = 1'b0;
        y_b[1] = 1'b1;
        @(negedge clk);
        while (valid_b !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        n_tests++;
        if (valid_b !== 1'b1 || pend_b !== 8'h02) begin
            n_fail++;
            $display("FAIL midrst_pre: valid=%b pend=%h, required 1 02", valid_b, pend_b);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (valid_b !== 1'b0 || pend_b !== 8'h00 || cnt_b !== 4'd0 || ch_b !== 3'd0 || ovf_a !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_async: valid=%b pend=%h cnt=%0d ch=%0d ovf_a=%h, required 0 00 0 0 00",
                     valid_b, pend_b, cnt_b, ch_b, ovf_a);
        end
        y_b = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            n_tests++;
            if (valid_b !== 1'b0 || pend_b !== 8'h00) begin
                n_fail++;
                $display("FAIL midrst_discard: valid=%b pend=%h, required 0 00", valid_b, pend_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_round_robin();
        test_back_pressure();
        test_saturation();
        test_level_mode();
        test_reset_mid_report();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
